// File: rtl/rv_exec_unit.sv
`default_nettype none
// ============================================================================
//  Module   : rv_exec_unit
//  Purpose  : RV32I execute-stage slice. It holds the program-counter
//             register, an integer ALU and a branch comparator. The ALU and
//             the comparator are purely combinational. Only the PC is
//             registered.
//  Ports    : clk, reset       - rising-edge clock, synchronous active-high reset
//             enl, load        - PC load enable and load value (jump/branch target)
//             count            - current PC, used as the program-memory address
//             A1, A2, aluCont  - ALU operands and op code {funct7[5], funct3}
//             aluOut           - ALU result
//             func3, brA, brB  - branch condition and comparator operands
//             brnchOut         - branch taken
//             aluZero          - (aluOut == 0); present only when the build
//                                defines ALU_ZERO_FLAG_EN
//  Config   : ALU_ZERO_FLAG_EN - adds the aluZero output port
//  Revision : 1.0 - initial release
// ============================================================================
module rv_exec_unit #(
    parameter int          XLEN     = 32,
    parameter int unsigned PC_STEP  = 4,
    parameter int unsigned RESET_PC = 0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            enl,
    input  logic [XLEN-1:0] load,
    output logic [XLEN-1:0] count,
    input  logic [XLEN-1:0] A1,
    input  logic [XLEN-1:0] A2,
    input  logic [3:0]      aluCont,
    output logic [XLEN-1:0] aluOut,
    input  logic [2:0]      func3,
    input  logic [XLEN-1:0] brA,
    input  logic [XLEN-1:0] brB,
    output logic            brnchOut
`ifdef ALU_ZERO_FLAG_EN
    ,
    output logic            aluZero
`endif
);

    // Shift amount width: 5 bits for a 32-bit datapath.
    localparam int c_SHW = $clog2(XLEN);

    localparam logic [XLEN-1:0] c_PC_STEP  = XLEN'(PC_STEP);
    localparam logic [XLEN-1:0] c_RESET_PC = XLEN'(RESET_PC);

    // ALU op codes, {funct7[5], funct3}
    localparam logic [3:0] c_OP_ADD  = 4'b0000;
    localparam logic [3:0] c_OP_SUB  = 4'b1000;
    localparam logic [3:0] c_OP_SLL  = 4'b0001;
    localparam logic [3:0] c_OP_SLT  = 4'b0010;
    localparam logic [3:0] c_OP_SLTU = 4'b0011;
    localparam logic [3:0] c_OP_XOR  = 4'b0100;
    localparam logic [3:0] c_OP_SRL  = 4'b0101;
    localparam logic [3:0] c_OP_SRA  = 4'b1101;
    localparam logic [3:0] c_OP_OR   = 4'b0110;
    localparam logic [3:0] c_OP_AND  = 4'b0111;

    // Branch conditions, B-type funct3
    localparam logic [2:0] c_BR_BEQ  = 3'b000;
    localparam logic [2:0] c_BR_BNE  = 3'b001;
    localparam logic [2:0] c_BR_BLT  = 3'b100;
    localparam logic [2:0] c_BR_BGE  = 3'b101;
    localparam logic [2:0] c_BR_BLTU = 3'b110;
    localparam logic [2:0] c_BR_BGEU = 3'b111;

    // ------------------------------------------------------------------
    // Program counter
    // ------------------------------------------------------------------
    logic [XLEN-1:0] r_pc;

    // Reset has priority over a load. The increment wraps naturally at
    // XLEN bits. The load value is taken verbatim, with no alignment
    // masking.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc <= c_RESET_PC;
        end else if (enl) begin
            r_pc <= load;
        end else begin
            r_pc <= r_pc + c_PC_STEP;
        end
    end

    assign count = r_pc;

    // ------------------------------------------------------------------
    // ALU
    // ------------------------------------------------------------------
    logic [c_SHW-1:0] w_shamt;
    logic             w_alu_slt;
    logic             w_alu_sltu;
    logic [XLEN-1:0]  w_alu;

    assign w_shamt    = A2[c_SHW-1:0];
    assign w_alu_slt  = $signed(A1) < $signed(A2);
    assign w_alu_sltu = A1 < A2;

    always_comb begin
        w_alu = '0;
        case (aluCont)
            c_OP_ADD:  w_alu = A1 + A2;
            c_OP_SUB:  w_alu = A1 - A2;
            c_OP_SLL:  w_alu = A1 << w_shamt;
            c_OP_SLT:  w_alu = {{(XLEN-1){1'b0}}, w_alu_slt};
            c_OP_SLTU: w_alu = {{(XLEN-1){1'b0}}, w_alu_sltu};
            c_OP_XOR:  w_alu = A1 ^ A2;
            c_OP_SRL:  w_alu = A1 >> w_shamt;
            c_OP_SRA:  w_alu = $unsigned($signed(A1) >>> w_shamt);
            c_OP_OR:   w_alu = A1 | A2;
            c_OP_AND:  w_alu = A1 & A2;
            // The remaining encodings are not RV32I register ops and
            // produce zero.
            default:   w_alu = '0;
        endcase
    end

    assign aluOut = w_alu;

`ifdef ALU_ZERO_FLAG_EN
    assign aluZero = (w_alu == '0);
`endif

    // ------------------------------------------------------------------
    // Branch comparator
    // ------------------------------------------------------------------
    logic w_br_eq;
    logic w_br_lt;
    logic w_br_ltu;
    logic w_br;

    assign w_br_eq  = (brA == brB);
    assign w_br_lt  = $signed(brA) < $signed(brB);
    assign w_br_ltu = brA < brB;

    always_comb begin
        w_br = 1'b0;
        case (func3)
            c_BR_BEQ:  w_br = w_br_eq;
            c_BR_BNE:  w_br = ~w_br_eq;
            c_BR_BLT:  w_br = w_br_lt;
            c_BR_BGE:  w_br = ~w_br_lt;
            c_BR_BLTU: w_br = w_br_ltu;
            c_BR_BGEU: w_br = ~w_br_ltu;
            // 010 and 011 are not branch encodings; the branch is never taken.
            default:   w_br = 1'b0;
        endcase
    end

    assign brnchOut = w_br;

endmodule
`default_nettype wire

// File: tb/tb_rv_exec_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rv_exec_unit
//  Purpose  : Self-checking bench for rv_exec_unit. The stimulus process pushes
//             expected responses into a queue. A monitor pops each entry and
//             compares it with the DUT outputs once per cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_rv_exec_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        enl = 1'b0;
    logic [31:0] load = '0;
    logic [31:0] count;
    logic [31:0] A1 = '0;
    logic [31:0] A2 = '0;
    logic [3:0]  aluCont = '0;
    logic [31:0] aluOut;
    logic [2:0]  func3 = '0;
    logic [31:0] brA = '0;
    logic [31:0] brB = '0;
    logic        brnchOut;
`ifdef ALU_ZERO_FLAG_EN
    logic        aluZero;
`endif

    rv_exec_unit #(.XLEN(32), .PC_STEP(4), .RESET_PC(0)) dut (
        .clk      (clk),
        .reset    (reset),
        .enl      (enl),
        .load     (load),
        .count    (count),
        .A1       (A1),
        .A2       (A2),
        .aluCont  (aluCont),
        .aluOut   (aluOut),
        .func3    (func3),
        .brA      (brA),
        .brB      (brB),
        .brnchOut (brnchOut)
`ifdef ALU_ZERO_FLAG_EN
        ,
        .aluZero  (aluZero)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        chk_pc;
        logic [31:0] pc;
        logic [31:0] alu;
        logic        br;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference model state
    logic [31:0] m_pc = '0;
    logic        m_pc_valid = 1'b0;

    // Reference ALU, written from the instruction semantics
    function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                            input logic [3:0] op);
        int          sa = a;
        int          sb = b;
        int unsigned sh = b % 32;
        logic [31:0] fill;
        case (op)
            4'd0:  return a + b;
            4'd8:  return a - b;
            4'd1:  return a << sh;
            4'd2:  return (sa < sb) ? 32'd1 : 32'd0;
            4'd3:  return (a < b) ? 32'd1 : 32'd0;
            4'd4:  return a ^ b;
            4'd5:  return a >> sh;
            4'd13: begin
                fill = a[31] ? ~(32'hFFFF_FFFF >> sh) : 32'd0;
                return (a >> sh) | fill;
            end
            4'd6:  return a | b;
            4'd7:  return a & b;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic ref_br(input logic [2:0] f, input logic [31:0] a,
                                    input logic [31:0] b);
        int sa = a;
        int sb = b;
        case (f)
            3'd0: return a == b;
            3'd1: return a != b;
            3'd4: return sa < sb;
            3'd5: return sa >= sb;
            3'd6: return a < b;
            3'd7: return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    // Drive one cycle of stimulus and queue the response expected during it.
    task automatic drive(input logic r, input logic e, input logic [31:0] ld,
                         input logic [31:0] a1, input logic [31:0] a2,
                         input logic [3:0] op, input logic [2:0] f,
                         input logic [31:0] ba, input logic [31:0] bb);
        exp_t x;
        @(posedge clk);
        #1;
        reset = r; enl = e; load = ld;
        A1 = a1; A2 = a2; aluCont = op;
        func3 = f; brA = ba; brB = bb;
        x.chk_pc = m_pc_valid;
        x.pc     = m_pc;
        x.alu    = ref_alu(a1, a2, op);
        x.br     = ref_br(f, ba, bb);
        q.push_back(x);
        if (r) begin
            m_pc = 32'd0;
            m_pc_valid = 1'b1;
        end else if (e) begin
            m_pc = ld;
        end else begin
            m_pc = m_pc + 32'd4;
        end
    endtask

    // Monitor
    initial begin
        exp_t x;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                x = q.pop_front();
                if (x.chk_pc) begin
                    n_tests++;
                    if (count !== x.pc) begin
                        n_fail++;
                        $display("FAIL count: got %h expected %h", count, x.pc);
                    end
                end
                n_tests++;
                if (aluOut !== x.alu) begin
                    n_fail++;
                    $display("FAIL aluOut op=%b A1=%h A2=%h: got %h expected %h",
                             aluCont, A1, A2, aluOut, x.alu);
                end
                n_tests++;
                if (brnchOut !== x.br) begin
                    n_fail++;
                    $display("FAIL brnchOut f=%b A=%h B=%h: got %b expected %b",
                             func3, brA, brB, brnchOut, x.br);
                end
`ifdef ALU_ZERO_FLAG_EN
                n_tests++;
                if (aluZero !== (x.alu == 32'd0)) begin
                    n_fail++;
                    $display("FAIL aluZero: got %b expected %b", aluZero, (x.alu == 32'd0));
                end
`endif
            end
        end
    end

    // Stimulus
    initial begin
        logic [31:0] a, b, ba, bb, ld;
        logic        r, e;
        // T1: reset, then free-running count
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (4) drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        // T2: load, then reset overriding a load
        drive(0, 1, 32'h100, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(1, 1, 32'h55, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        // T3: ALU arithmetic and compares
        drive(0, 0, 0, 3, 3, 4'b0000, 0, 0, 0);
        drive(0, 0, 0, -32'sd10, 3, 4'b0010, 0, 0, 0);
        drive(0, 0, 0, -32'sd10, 3, 4'b0011, 0, 0, 0);
        drive(0, 0, 0, -32'sd10, 3, 4'b1000, 0, 0, 0);
        // T4: shifts and an unlisted op code
        drive(0, 0, 0, 32'h8000_0000, 4, 4'b1101, 0, 0, 0);
        drive(0, 0, 0, 32'h8000_0000, 4, 4'b0101, 0, 0, 0);
        drive(0, 0, 0, 32'h8000_0000, 4, 4'b0001, 0, 0, 0);
        drive(0, 0, 0, 32'h8000_0000, 4, 4'b1111, 0, 0, 0);
        // T5: branches
        drive(0, 0, 0, 0, 0, 0, 3'd0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 3'd1, 1, 1);
        drive(0, 0, 0, 0, 0, 0, 3'd4, -32'sd3, 2);
        drive(0, 0, 0, 0, 0, 0, 3'd6, -32'sd3, 3);
        drive(0, 0, 0, 0, 0, 0, 3'd5, 10, 3);
        drive(0, 0, 0, 0, 0, 0, 3'd7, -32'sd10, 3);
        drive(0, 0, 0, 0, 0, 0, 3'd2, 5, 5);
        // T6: PC wrap and a zero ALU result
        drive(0, 1, 32'hFFFF_FFFC, 5, 5, 4'b1000, 0, 0, 0);
        drive(0, 0, 0, 5, 5, 4'b1000, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            r  = ($urandom_range(0, 49) == 0);
            e  = ($urandom_range(0, 5) == 0);
            ld = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15))
                                              : $urandom;
            a  = $urandom;
            case ($urandom_range(0, 3))
                0:       b = a;
                1:       b = 32'($urandom_range(0, 40));
                default: b = $urandom;
            endcase
            ba = $urandom;
            case ($urandom_range(0, 3))
                0:       bb = ba;
                1:       bb = ~ba;
                2:       bb = ba ^ 32'h8000_0000;
                default: bb = $urandom;
            endcase
            drive(r, e, ld, a, b, 4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)), ba, bb);
        end
        // Drain the scoreboard within a bounded number of cycles.
        for (int i = 0; i < 5 && q.size() > 0; i++) @(negedge clk);
        #1;
        n_tests++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
